// File: rtl/ethernet_slot_control_unit.sv
// Slot bookkeeping for a small MMIO Ethernet MAC: RX fill queue, TX command FIFO,
// event/irq registers and routing of MMIO accesses to the packet buffer.
module ethernet_slot_control_unit #(
    parameter int eth_mtu_p    = 2048,
    parameter int data_width_p = 32,
    parameter int rx_slots_p   = 2,
    parameter int tx_slots_p   = 2,
    localparam int size_width_lp     = $clog2($clog2(data_width_p/8)+1),
    localparam int buf_addr_width_lp = $clog2((rx_slots_p+tx_slots_p)*eth_mtu_p),
    localparam int len_width_lp      = $clog2(eth_mtu_p+1),
    localparam int addr_width_lp     = 16,
    localparam int rx_slot_width_lp  = (rx_slots_p > 1) ? $clog2(rx_slots_p) : 1,
    localparam int tx_slot_width_lp  = (tx_slots_p > 1) ? $clog2(tx_slots_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [addr_width_lp-1:0]     addr_i,
    input  logic                         write_en_i,
    input  logic                         read_en_i,
    input  logic [size_width_lp-1:0]     op_size_i,
    input  logic [data_width_p-1:0]      write_data_i,
    output logic [data_width_p-1:0]      read_data_o,
    output logic                         io_decode_error_o,
    output logic                         buf_rvalid_o,
    output logic [buf_addr_width_lp-1:0] buf_raddr_o,
    output logic [size_width_lp-1:0]     buf_rdata_size_o,
    input  logic [data_width_p-1:0]      buf_rdata_i,
    output logic                         buf_wvalid_o,
    output logic [buf_addr_width_lp-1:0] buf_waddr_o,
    output logic [data_width_p-1:0]      buf_wdata_o,
    output logic [size_width_lp-1:0]     buf_wdata_size_o,
    output logic [rx_slot_width_lp-1:0]  rx_slot_o,
    output logic                         rx_slot_v_o,
    input  logic                         rx_done_i,
    input  logic [len_width_lp-1:0]      rx_len_i,
    output logic                         tx_v_o,
    input  logic                         tx_ready_i,
    output logic [tx_slot_width_lp-1:0]  tx_slot_o,
    output logic [len_width_lp-1:0]      tx_len_o,
    input  logic                         tx_done_i,
    output logic                         irq_o
);
    localparam int rx_cnt_width_lp = $clog2(rx_slots_p+1);
    localparam int tx_cnt_width_lp = $clog2(tx_slots_p+1);
    localparam logic [rx_cnt_width_lp-1:0]  rx_depth_lp  = rx_cnt_width_lp'(rx_slots_p);
    localparam logic [tx_cnt_width_lp-1:0]  tx_depth_lp  = tx_cnt_width_lp'(tx_slots_p);
    localparam logic [rx_slot_width_lp-1:0] rx_last_lp   = rx_slot_width_lp'(rx_slots_p-1);
    localparam logic [tx_slot_width_lp-1:0] tx_last_lp   = tx_slot_width_lp'(tx_slots_p-1);
    localparam logic [addr_width_lp-1:0]    rx_bytes_lp  = addr_width_lp'(rx_slots_p*eth_mtu_p);
    localparam logic [addr_width_lp-1:0]    buf_bytes_lp = addr_width_lp'((rx_slots_p+tx_slots_p)*eth_mtu_p);
    localparam logic [len_width_lp-1:0]     mtu_len_lp   = len_width_lp'(eth_mtu_p);

    logic [rx_slot_width_lp-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [rx_cnt_width_lp-1:0]  r_rx_count;
    logic [len_width_lp-1:0]     r_rx_len_mem [rx_slots_p];
    logic [31:0]                 r_wr_errors;
    logic                        r_wr_ev_enable, r_rd_ev_enable, r_rd_ev_pending;
    logic [tx_slot_width_lp-1:0] r_rd_slot;
    logic [len_width_lp-1:0]     r_rd_len;
    logic [tx_slot_width_lp-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [tx_cnt_width_lp-1:0]  r_tx_count;
    logic [tx_slot_width_lp-1:0] r_tx_slot_mem [tx_slots_p];
    logic [len_width_lp-1:0]     r_tx_len_mem [tx_slots_p];
    logic [data_width_p-1:0]     r_read_data;
    logic                        r_buf_rd_pend;
    logic                        r_irq;

    logic       w_is_buf, w_is_rx, w_is_csr, w_csr_readable, w_csr_writable;
    logic [7:0] w_csr_off;
    logic       w_wr_req, w_rd_req, w_wr_err, w_rd_err, w_wr_ok, w_rd_ok, w_csr_we;
    logic       w_rx_empty, w_tx_full, w_rx_push, w_rx_pop, w_rx_drop, w_tx_push, w_tx_pop, w_rd_clear;
    logic [rx_cnt_width_lp-1:0]  w_rx_count_next;
    logic [tx_cnt_width_lp-1:0]  w_tx_count_next;
    logic                        w_wr_en_next, w_rd_en_next, w_rd_pend_next;
    logic [rx_slot_width_lp-1:0] w_rx_wr_inc, w_rx_rd_inc;
    logic [tx_slot_width_lp-1:0] w_tx_wr_inc, w_tx_rd_inc;
    logic [data_width_p-1:0]     w_csr_rdata;

    assign w_is_buf  = addr_i < buf_bytes_lp;
    assign w_is_rx   = addr_i < rx_bytes_lp;
    assign w_is_csr  = addr_i[15:8] == 8'h80;
    assign w_csr_off = addr_i[7:0];

    always_comb begin
        w_csr_readable = 1'b0;
        w_csr_writable = 1'b0;
        case (w_csr_off)
            8'h00, 8'h04, 8'h08, 8'h1C, 8'h20: w_csr_readable = 1'b1;
            8'h10, 8'h14, 8'h24, 8'h28, 8'h30, 8'h34: begin
                w_csr_readable = 1'b1;
                w_csr_writable = 1'b1;
            end
            8'h18:   w_csr_writable = 1'b1;
            default: ;
        endcase
    end

    // A READER_START into a full FIFO is refused like any other illegal access.
    assign w_wr_err = w_is_buf ? w_is_rx
                    : (w_is_csr ? (!w_csr_writable || (w_csr_off == 8'h18 && w_tx_full)) : 1'b1);
    assign w_rd_err = w_is_buf ? !w_is_rx : (w_is_csr ? !w_csr_readable : 1'b1);
    assign w_wr_req = write_en_i && !read_en_i && !reset_i;
    assign w_rd_req = read_en_i && !write_en_i && !reset_i;
    assign w_wr_ok  = w_wr_req && !w_wr_err;
    assign w_rd_ok  = w_rd_req && !w_rd_err;
    assign w_csr_we = w_wr_ok && w_is_csr;
    assign io_decode_error_o = !reset_i && ((read_en_i && write_en_i) ||
                               (w_wr_req && w_wr_err) || (w_rd_req && w_rd_err));

    assign buf_rvalid_o     = w_rd_ok && w_is_buf;
    assign buf_raddr_o      = addr_i[buf_addr_width_lp-1:0];
    assign buf_rdata_size_o = op_size_i;
    assign buf_wvalid_o     = w_wr_ok && w_is_buf;
    assign buf_waddr_o      = addr_i[buf_addr_width_lp-1:0];
    assign buf_wdata_o      = write_data_i;
    assign buf_wdata_size_o = op_size_i;

    assign w_rx_empty  = r_rx_count == '0;
    assign w_tx_full   = r_tx_count == tx_depth_lp;
    assign rx_slot_o   = r_rx_wr_ptr;
    assign rx_slot_v_o = r_rx_count != rx_depth_lp;
    assign tx_v_o      = r_tx_count != '0;
    assign tx_slot_o   = r_tx_slot_mem[r_tx_rd_ptr];
    assign tx_len_o    = r_tx_len_mem[r_tx_rd_ptr];
    assign irq_o       = r_irq;
    assign read_data_o = r_buf_rd_pend ? buf_rdata_i : r_read_data;

    assign w_rx_push  = rx_done_i && rx_slot_v_o;
    assign w_rx_drop  = rx_done_i && !rx_slot_v_o;
    assign w_rx_pop   = w_csr_we && w_csr_off == 8'h10 && write_data_i[0] && !w_rx_empty;
    assign w_tx_push  = w_csr_we && w_csr_off == 8'h18;
    assign w_tx_pop   = tx_v_o && tx_ready_i;
    assign w_rd_clear = w_csr_we && w_csr_off == 8'h30 && write_data_i[0];

    assign w_rx_count_next = r_rx_count + rx_cnt_width_lp'(w_rx_push) - rx_cnt_width_lp'(w_rx_pop);
    assign w_tx_count_next = r_tx_count + tx_cnt_width_lp'(w_tx_push) - tx_cnt_width_lp'(w_tx_pop);
    assign w_wr_en_next    = (w_csr_we && w_csr_off == 8'h14) ? write_data_i[0] : r_wr_ev_enable;
    assign w_rd_en_next    = (w_csr_we && w_csr_off == 8'h34) ? write_data_i[0] : r_rd_ev_enable;
    assign w_rd_pend_next  = tx_done_i || (r_rd_ev_pending && !w_rd_clear);

    assign w_rx_wr_inc = (r_rx_wr_ptr == rx_last_lp) ? '0 : r_rx_wr_ptr + rx_slot_width_lp'(1);
    assign w_rx_rd_inc = (r_rx_rd_ptr == rx_last_lp) ? '0 : r_rx_rd_ptr + rx_slot_width_lp'(1);
    assign w_tx_wr_inc = (r_tx_wr_ptr == tx_last_lp) ? '0 : r_tx_wr_ptr + tx_slot_width_lp'(1);
    assign w_tx_rd_inc = (r_tx_rd_ptr == tx_last_lp) ? '0 : r_tx_rd_ptr + tx_slot_width_lp'(1);

    // RX slots are handed out in order, so the head slot is the read pointer itself.
    always_comb begin
        w_csr_rdata = '0;
        case (w_csr_off)
            8'h00: w_csr_rdata = w_rx_empty ? '0 : data_width_p'(r_rx_rd_ptr);
            8'h04: w_csr_rdata = w_rx_empty ? '0 : data_width_p'(r_rx_len_mem[r_rx_rd_ptr]);
            8'h08: w_csr_rdata = data_width_p'(r_wr_errors);
            8'h10: w_csr_rdata = data_width_p'(!w_rx_empty);
            8'h14: w_csr_rdata = data_width_p'(r_wr_ev_enable);
            8'h1C: w_csr_rdata = data_width_p'(!w_tx_full);
            8'h20: w_csr_rdata = data_width_p'(r_tx_count);
            8'h24: w_csr_rdata = data_width_p'(r_rd_slot);
            8'h28: w_csr_rdata = data_width_p'(r_rd_len);
            8'h30: w_csr_rdata = data_width_p'(r_rd_ev_pending);
            8'h34: w_csr_rdata = data_width_p'(r_rd_ev_enable);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_len_mem[r_rx_wr_ptr] <= rx_len_i;
        if (w_tx_push) begin
            r_tx_slot_mem[r_tx_wr_ptr] <= r_rd_slot;
            r_tx_len_mem[r_tx_wr_ptr]  <= r_rd_len;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_wr_ptr     <= '0;
            r_rx_rd_ptr     <= '0;
            r_rx_count      <= '0;
            r_wr_errors     <= '0;
            r_wr_ev_enable  <= 1'b0;
            r_rd_ev_enable  <= 1'b0;
            r_rd_ev_pending <= 1'b0;
            r_rd_slot       <= '0;
            r_rd_len        <= '0;
            r_tx_wr_ptr     <= '0;
            r_tx_rd_ptr     <= '0;
            r_tx_count      <= '0;
            r_read_data     <= '0;
            r_buf_rd_pend   <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= w_rx_wr_inc;
            if (w_rx_pop)  r_rx_rd_ptr <= w_rx_rd_inc;
            if (w_tx_push) r_tx_wr_ptr <= w_tx_wr_inc;
            if (w_tx_pop)  r_tx_rd_ptr <= w_tx_rd_inc;
            r_rx_count      <= w_rx_count_next;
            r_tx_count      <= w_tx_count_next;
            r_wr_ev_enable  <= w_wr_en_next;
            r_rd_ev_enable  <= w_rd_en_next;
            r_rd_ev_pending <= w_rd_pend_next;
            if (w_rx_drop && r_wr_errors != '1) r_wr_errors <= r_wr_errors + 32'd1;
            if (w_csr_we && w_csr_off == 8'h24) r_rd_slot <= write_data_i[tx_slot_width_lp-1:0] & tx_last_lp;
            if (w_csr_we && w_csr_off == 8'h28)
                r_rd_len <= (write_data_i > data_width_p'(eth_mtu_p)) ? mtu_len_lp : write_data_i[len_width_lp-1:0];
            // Buffer read data is captured one cycle late so it stays visible until the next read.
            r_buf_rd_pend <= buf_rvalid_o;
            if (w_rd_ok && w_is_csr) r_read_data <= w_csr_rdata;
            else if (r_buf_rd_pend)  r_read_data <= buf_rdata_i;
            r_irq <= ((w_rx_count_next != '0) && w_wr_en_next) || (w_rd_pend_next && w_rd_en_next);
        end
    end
endmodule

// File: tb/tb_ethernet_slot_control_unit.sv
// Bench for ethernet_slot_control_unit: randomized traffic against a queue-based model,
// followed by directed scenarios with literal expectations.
module tb_ethernet_slot_control_unit;
    localparam int MTU = 2048;
    localparam int RXS = 2;
    localparam int TXS = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] addr_i;
    logic        write_en_i, read_en_i;
    logic [1:0]  op_size_i;
    logic [31:0] write_data_i, read_data_o;
    logic        io_decode_error_o;
    logic        buf_rvalid_o;
    logic [12:0] buf_raddr_o;
    logic [1:0]  buf_rdata_size_o;
    logic [31:0] buf_rdata_i;
    logic        buf_wvalid_o;
    logic [12:0] buf_waddr_o;
    logic [31:0] buf_wdata_o;
    logic [1:0]  buf_wdata_size_o;
    logic        rx_slot_o, rx_slot_v_o, rx_done_i;
    logic [11:0] rx_len_i;
    logic        tx_v_o, tx_ready_i, tx_slot_o;
    logic [11:0] tx_len_o;
    logic        tx_done_i, irq_o;

    always #5 clk_i = ~clk_i;

    ethernet_slot_control_unit #(.eth_mtu_p(MTU), .data_width_p(32), .rx_slots_p(RXS), .tx_slots_p(TXS)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .write_en_i(write_en_i),
        .read_en_i(read_en_i), .op_size_i(op_size_i), .write_data_i(write_data_i),
        .read_data_o(read_data_o), .io_decode_error_o(io_decode_error_o),
        .buf_rvalid_o(buf_rvalid_o), .buf_raddr_o(buf_raddr_o), .buf_rdata_size_o(buf_rdata_size_o),
        .buf_rdata_i(buf_rdata_i), .buf_wvalid_o(buf_wvalid_o), .buf_waddr_o(buf_waddr_o),
        .buf_wdata_o(buf_wdata_o), .buf_wdata_size_o(buf_wdata_size_o),
        .rx_slot_o(rx_slot_o), .rx_slot_v_o(rx_slot_v_o), .rx_done_i(rx_done_i), .rx_len_i(rx_len_i),
        .tx_v_o(tx_v_o), .tx_ready_i(tx_ready_i), .tx_slot_o(tx_slot_o), .tx_len_o(tx_len_o),
        .tx_done_i(tx_done_i), .irq_o(irq_o)
    );

    typedef struct { int slot; int len; } ent_t;
    ent_t        rxq[$];
    ent_t        txq[$];
    int          rx_next, m_rd_slot, m_rd_len;
    logic [31:0] m_errs, m_rdata;
    bit          m_wr_en, m_rd_en, m_rd_pend, m_irq, buf_rd_prev, rdata_fixed;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // 0 = RX buffer, 1 = TX buffer, 2 = CSR page, 3 = nothing
    function automatic int region(input int a);
        if (a < RXS*MTU) return 0;
        if (a < (RXS+TXS)*MTU) return 1;
        if (a >= 'h8000 && a < 'h8100) return 2;
        return 3;
    endfunction

    function automatic bit readable(input int off);
        return off inside {'h00, 'h04, 'h08, 'h10, 'h14, 'h1C, 'h20, 'h24, 'h28, 'h30, 'h34};
    endfunction

    function automatic bit writable(input int off);
        return off inside {'h10, 'h14, 'h18, 'h24, 'h28, 'h30, 'h34};
    endfunction

    function automatic bit model_err();
        int r;
        int off;
        r = region(int'(addr_i));
        off = int'(addr_i) - 'h8000;
        if (reset_i) return 1'b0;
        if (read_en_i && write_en_i) return 1'b1;
        if (write_en_i) begin
            if (r == 0 || r == 3) return 1'b1;
            if (r == 2) return !writable(off) || (off == 'h18 && txq.size() == TXS);
            return 1'b0;
        end
        if (read_en_i) begin
            if (r == 1 || r == 3) return 1'b1;
            if (r == 2) return !readable(off);
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] csr_value(input int off);
        case (off)
            'h00: return (rxq.size() != 0) ? rxq[0].slot : 0;
            'h04: return (rxq.size() != 0) ? rxq[0].len : 0;
            'h08: return m_errs;
            'h10: return {31'd0, rxq.size() != 0};
            'h14: return {31'd0, m_wr_en};
            'h1C: return {31'd0, txq.size() < TXS};
            'h20: return txq.size();
            'h24: return m_rd_slot;
            'h28: return m_rd_len;
            'h30: return {31'd0, m_rd_pend};
            'h34: return {31'd0, m_rd_en};
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        rxq.delete(); txq.delete();
        rx_next = 0; m_rd_slot = 0; m_rd_len = 0; m_errs = 0; m_rdata = 0;
        m_wr_en = 0; m_rd_en = 0; m_rd_pend = 0; m_irq = 0; buf_rd_prev = 0;
    endtask

    task automatic idle_inputs();
        addr_i = 0; write_en_i = 0; read_en_i = 0; write_data_i = 0; op_size_i = 0;
        rx_done_i = 0; rx_len_i = 0; tx_done_i = 0;
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic step();
        bit err, rd_ok, wr_ok, rx_pop, rx_push, tx_pop, tx_push, clr;
        int r, off;
        ent_t e;
        if (!rdata_fixed) buf_rdata_i = $urandom;
        if (buf_rd_prev) m_rdata = buf_rdata_i;
        #1;
        err   = model_err();
        r     = region(int'(addr_i));
        off   = int'(addr_i) - 'h8000;
        rd_ok = read_en_i && !write_en_i && !err;
        wr_ok = write_en_i && !read_en_i && !err;
        check("read_data", read_data_o, m_rdata);
        check("irq", irq_o, m_irq);
        check("decode_err", io_decode_error_o, err);
        check("buf_rvalid", buf_rvalid_o, rd_ok && r == 0);
        check("buf_wvalid", buf_wvalid_o, wr_ok && r == 1);
        if (rd_ok && r == 0) begin
            check("buf_raddr", buf_raddr_o, addr_i);
            check("buf_rsize", buf_rdata_size_o, op_size_i);
        end
        if (wr_ok && r == 1) begin
            check("buf_waddr", buf_waddr_o, addr_i);
            check("buf_wdata", buf_wdata_o, write_data_i);
            check("buf_wsize", buf_wdata_size_o, op_size_i);
        end
        check("rx_slot_v", rx_slot_v_o, rxq.size() < RXS);
        if (rxq.size() < RXS) check("rx_slot", rx_slot_o, rx_next);
        check("tx_v", tx_v_o, txq.size() != 0);
        if (txq.size() != 0) begin
            check("tx_slot", tx_slot_o, txq[0].slot);
            check("tx_len", tx_len_o, txq[0].len);
        end

        if (rd_ok && r == 2) m_rdata = csr_value(off);
        buf_rd_prev = rd_ok && r == 0;
        rx_pop  = wr_ok && r == 2 && off == 'h10 && write_data_i[0] && rxq.size() != 0;
        rx_push = rx_done_i && rxq.size() < RXS;
        tx_pop  = txq.size() != 0 && tx_ready_i;
        tx_push = wr_ok && r == 2 && off == 'h18;
        clr     = wr_ok && r == 2 && off == 'h30 && write_data_i[0];
        if (rx_done_i && !rx_push && m_errs != 32'hFFFF_FFFF) m_errs++;
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) begin
            e.slot = rx_next; e.len = int'(rx_len_i);
            rxq.push_back(e);
            rx_next = (rx_next + 1) % RXS;
        end
        if (tx_pop) void'(txq.pop_front());
        if (tx_push) begin
            e.slot = m_rd_slot; e.len = m_rd_len;
            txq.push_back(e);
        end
        if (wr_ok && r == 2) begin
            case (off)
                'h14: m_wr_en = write_data_i[0];
                'h34: m_rd_en = write_data_i[0];
                'h24: m_rd_slot = int'(write_data_i % TXS);
                'h28: m_rd_len = (write_data_i > MTU) ? MTU : int'(write_data_i);
                default: ;
            endcase
        end
        m_rd_pend = tx_done_i || (m_rd_pend && !clr);
        m_irq = (rxq.size() != 0 && m_wr_en) || (m_rd_pend && m_rd_en);
        @(posedge clk_i);
        #1;
    endtask

    task automatic mmio(input bit we, input bit re, input logic [15:0] a, input logic [31:0] d);
        addr_i = a; write_en_i = we; read_en_i = re; write_data_i = d;
        op_size_i = 2'($urandom_range(0, 3));
        step();
        write_en_i = 0; read_en_i = 0; rx_done_i = 0; tx_done_i = 0;
    endtask

    task automatic csr_read_expect(input string tag, input logic [15:0] a, input logic [31:0] exp);
        mmio(0, 1, a, 0);
        check(tag, read_data_o, exp);
    endtask

    task automatic rx_frame(input int len);
        rx_done_i = 1; rx_len_i = 12'(len);
        step();
        rx_done_i = 0;
    endtask

    task automatic do_reset();
        reset_i = 1; tx_ready_i = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 0;
    endtask

    initial begin
        int offs[15] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h24, 'h28, 'h2C, 'h30, 'h34, 'h38};
        rdata_fixed = 0;
        buf_rdata_i = 0;
        reset_i = 1; tx_ready_i = 0;
        idle_inputs();
        model_reset();

        // Outputs held quiet while reset is asserted.
        read_en_i = 1; addr_i = 16'h0010;
        @(posedge clk_i); #1;
        check("rst_rvalid", buf_rvalid_o, 0);
        check("rst_tx_v", tx_v_o, 0);
        check("rst_read_data", read_data_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_rx_slot", rx_slot_o, 0);
        read_en_i = 0; write_en_i = 1; addr_i = 16'h1000; #1;
        check("rst_wvalid", buf_wvalid_o, 0);
        read_en_i = 1; #1;
        check("rst_decode_err", io_decode_error_o, 0);
        idle_inputs();
        @(posedge clk_i); #1;
        reset_i = 0;

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            int kind, off;
            logic [31:0] d;
            rx_done_i  = ($urandom_range(0, 3) == 0);
            rx_len_i   = 12'($urandom_range(0, MTU));
            tx_ready_i = $urandom_range(0, 1);
            tx_done_i  = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 9);
            off  = offs[$urandom_range(0, 14)];
            case (kind)
                0, 1: mmio(0, 1, 16'('h8000 + off), 0);
                2, 3: begin
                    d = $urandom;
                    if (off == 'h28 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 2100);
                    if (off == 'h10 || off == 'h30) d = $urandom_range(0, 3);
                    mmio(1, 0, 16'('h8000 + off), d);
                end
                4:    mmio(0, 1, 16'($urandom_range(0, 8191)), 0);
                5:    mmio(1, 0, 16'($urandom_range(0, 8191)), $urandom);
                6:    mmio($urandom_range(0, 1) == 1, 1'b0, 16'($urandom_range(0, 1) == 1 ?
                           $urandom_range('h2000, 'h7FFF) : $urandom_range('h8100, 'hFFFF)), $urandom);
                7:    mmio(1, 1, 16'($urandom_range(0, 'hFFFF)), $urandom);
                default: mmio(0, 0, 0, 0);
            endcase
        end

        // RX queue overflow and drop counting.
        do_reset();
        rx_frame(60);
        rx_frame(64);
        rx_frame(70);
        check("req023_rx_slot_v", rx_slot_v_o, 0);
        csr_read_expect("req023_errors", 16'h8008, 1);
        csr_read_expect("req023_head_slot", 16'h8000, 0);
        csr_read_expect("req023_head_len", 16'h8004, 60);
        mmio(1, 0, 16'h8010, 1);
        csr_read_expect("req024_slot", 16'h8000, 1);
        csr_read_expect("req024_len", 16'h8004, 64);
        mmio(1, 0, 16'h8010, 1);
        csr_read_expect("req024_pending", 16'h8010, 0);
        csr_read_expect("req024_slot_empty", 16'h8000, 0);

        // TX command path with the transmitter stalled.
        mmio(1, 0, 16'h8024, 1);
        mmio(1, 0, 16'h8028, 100);
        mmio(1, 0, 16'h8018, 0);
        check("req025_tx_v", tx_v_o, 1);
        check("req025_tx_slot", tx_slot_o, 1);
        check("req025_tx_len", tx_len_o, 100);
        csr_read_expect("req025_level", 16'h8020, 1);
        mmio(1, 0, 16'h8028, 5000);
        csr_read_expect("len_saturate", 16'h8028, MTU);
        mmio(1, 0, 16'h8018, 0);
        addr_i = 16'h8018; write_en_i = 1; #1;
        check("req026_err", io_decode_error_o, 1);
        step();
        write_en_i = 0;
        csr_read_expect("req026_ready", 16'h801C, 0);
        csr_read_expect("req026_level", 16'h8020, 2);

        // Reset in the middle of a handshake drops the pending command.
        tx_ready_i = 1; #2;
        reset_i = 1; #1;
        check("midrst_tx_v", tx_v_o, 0);
        @(posedge clk_i); #1;
        reset_i = 0; tx_ready_i = 0;
        model_reset();
        csr_read_expect("midrst_level", 16'h8020, 0);
        check("midrst_tx_v_after", tx_v_o, 0);

        // Set beats clear on READER_EV_PENDING.
        mmio(1, 0, 16'h8034, 1);
        check("req027_irq_before", irq_o, 0);
        tx_done_i = 1;
        mmio(1, 0, 16'h8030, 1);
        check("req027_irq", irq_o, 1);
        csr_read_expect("req027_pending", 16'h8030, 1);
        mmio(1, 0, 16'h8030, 1);
        mmio(0, 0, 0, 0);
        check("req027_irq_cleared", irq_o, 0);

        // Buffer read latency and an illegal RX-region write.
        addr_i = 16'h0804; read_en_i = 1; #1;
        check("req028_rvalid", buf_rvalid_o, 1);
        check("req028_raddr", buf_raddr_o, 13'h804);
        step();
        read_en_i = 0;
        rdata_fixed = 1;
        buf_rdata_i = 32'hCAFE_F00D;
        step();
        check("req028_rdata_held", read_data_o, 32'hCAFE_F00D);
        rdata_fixed = 0;
        addr_i = 16'h0010; write_en_i = 1; write_data_i = 32'h1234; #1;
        check("req028_wr_err", io_decode_error_o, 1);
        check("req028_no_wvalid", buf_wvalid_o, 0);
        step();
        idle_inputs();
        mmio(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ethernet_slot_control_unit.md
ETHERNET_SLOT_CONTROL_UNIT -- requirements
Module: ethernet_slot_control_unit

Interface
REQ-001 Parameters SHALL be:
- eth_mtu_p, default 2048: bytes per slot, power of 2, at most 2048.
- data_width_p, default 32: MMIO and buffer data width, 32 or 64.
- rx_slots_p, default 2: RX slots, power of 2, 1 to 4.
- tx_slots_p, default 2: TX slots, power of 2, 1 to 4.
REQ-002 Derived widths SHALL be:
- size_width_lp = width of clog2(data_width_p/8).
- buf_addr_width_lp = clog2((rx_slots_p+tx_slots_p)*eth_mtu_p).
- len_width_lp = clog2(eth_mtu_p+1).
- addr_width_lp = 16.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: single clock.
- reset_i, in, 1: asynchronous active-high reset.
- addr_i, in, 16; write_en_i, in, 1; read_en_i, in, 1; op_size_i, in, size_width_lp; write_data_i, in, data_width_p: MMIO request.
- read_data_o, out, data_width_p: MMIO read data. io_decode_error_o, out, 1: illegal access.
- buf_rvalid_o, out, 1; buf_raddr_o, out, buf_addr_width_lp; buf_rdata_size_o, out, size_width_lp; buf_rdata_i, in, data_width_p: buffer read port, 1-cycle latency.
- buf_wvalid_o, out, 1; buf_waddr_o, out, buf_addr_width_lp; buf_wdata_o, out, data_width_p; buf_wdata_size_o, out, size_width_lp: buffer write port.
- rx_slot_o, out, clog2(rx_slots_p) (min 1); rx_slot_v_o, out, 1: free slot offered to the receiver.
- rx_done_i, in, 1; rx_len_i, in, len_width_lp: receiver finished a frame into rx_slot_o.
- tx_v_o, out, 1; tx_ready_i, in, 1; tx_slot_o, out, clog2(tx_slots_p) (min 1); tx_len_o, out, len_width_lp: transmit command, valid/ready.
- tx_done_i, in, 1: transmitter finished a frame.
- irq_o, out, 1: combined interrupt.

Function
REQ-004 Address map SHALL be:
- Buffer region: 0x0000 to (rx_slots_p+tx_slots_p)*eth_mtu_p-1. RX slot k starts at k*eth_mtu_p. TX slot j starts at (rx_slots_p+j)*eth_mtu_p.
- CSR region: 0x8000 plus these offsets:
  - 0x00 WRITER_SLOT, R
  - 0x04 WRITER_LENGTH, R
  - 0x08 WRITER_ERRORS, R
  - 0x10 WRITER_EV_PENDING, R/W1C
  - 0x14 WRITER_EV_ENABLE, RW
  - 0x18 READER_START, W
  - 0x1C READER_READY, R
  - 0x20 READER_LEVEL, R
  - 0x24 READER_SLOT, RW
  - 0x28 READER_LENGTH, RW
  - 0x30 READER_EV_PENDING, R/W1C
  - 0x34 READER_EV_ENABLE, RW
REQ-005 Reads from the RX region SHALL assert buf_rvalid_o combinationally, and read_data_o SHALL return buf_rdata_i one cycle later.
REQ-006 Writes to the TX region SHALL assert buf_wvalid_o in the same cycle, passing data and size through unchanged.
REQ-007 CSR reads SHALL be registered, with 1-cycle latency; values are zero-extended to data_width_p; read_data_o holds its value until the next read.
REQ-008 io_decode_error_o SHALL pulse in the request cycle, with no state change, for any of:
- a write to the RX region;
- a read from the TX region;
- a read of a W-only register;
- a write to an R-only register;
- an unmapped address;
- read_en_i and write_en_i asserted together.
REQ-009 The RX fill queue SHALL be a FIFO of {slot, length} entries with depth rx_slots_p.
- rx_slot_o is the next free slot in round-robin order.
- rx_slot_v_o = queue not full.
REQ-010 rx_done_i with rx_slot_v_o=1 SHALL push {rx_slot_o, rx_len_i} and advance rx_slot_o modulo rx_slots_p.
REQ-011 rx_done_i with rx_slot_v_o=0 SHALL drop the frame and increment WRITER_ERRORS, which is 32 bits and saturates at 0xFFFFFFFF.
REQ-012 WRITER_EV_PENDING SHALL read 1 whenever the queue is non-empty. WRITER_SLOT and WRITER_LENGTH SHALL show the queue head, or 0 when the queue is empty.
REQ-013 Writing 1 to WRITER_EV_PENDING bit 0 SHALL pop the head. A pop while empty SHALL be ignored. A push and a pop in the same cycle SHALL both take effect.
REQ-014 The TX command FIFO SHALL have depth tx_slots_p.
- Writing READER_START pushes {READER_SLOT, READER_LENGTH}.
- READER_READY = FIFO not full.
- READER_LEVEL = FIFO occupancy.
REQ-015 READER_START while the FIFO is full SHALL be dropped and SHALL assert io_decode_error_o.
REQ-016 tx_v_o SHALL equal FIFO non-empty, with tx_slot_o/tx_len_o driven from the head; the head pops on tx_v_o & tx_ready_i.
REQ-017 A same-cycle TX push and pop SHALL leave the occupancy unchanged.
REQ-018 tx_done_i SHALL set the READER_EV_PENDING sticky bit.
- Writing 1 to it clears the bit.
- If tx_done_i and the clear occur in the same cycle, the set wins.
REQ-019 irq_o SHALL be registered: (WRITER_EV_PENDING & WRITER_EV_ENABLE) | (READER_EV_PENDING & READER_EV_ENABLE).
REQ-020 READER_LENGTH writes greater than eth_mtu_p SHALL saturate to eth_mtu_p. READER_SLOT writes SHALL keep only the low clog2(tx_slots_p) bits.

Reset
REQ-021 Asserting reset_i SHALL asynchronously clear all state:
- both FIFOs empty;
- rx_slot_o = 0;
- WRITER_ERRORS = 0;
- both enables and READER_EV_PENDING = 0;
- READER_SLOT and READER_LENGTH = 0;
- read_data_o = 0;
- irq_o = 0.
REQ-022 During reset, tx_v_o, buf_rvalid_o, buf_wvalid_o and io_decode_error_o SHALL be 0. A reset in the middle of a TX handshake SHALL discard the pending command.

Verification
REQ-023 rx_slots_p=2, three rx_done_i with lengths 60, 64 and 70 and no pops -> slots 0 and 1 are queued, WRITER_ERRORS=1, rx_slot_v_o=0.
REQ-024 After REQ-023, write 0x1 to 0x8010 -> WRITER_SLOT reads 1, WRITER_LENGTH reads 64; a second pop -> WRITER_EV_PENDING reads 0.
REQ-025 Set READER_SLOT=1 and READER_LENGTH=100, then READER_START with tx_ready_i=0 -> tx_v_o=1, tx_slot_o=1, tx_len_o=100, READER_LEVEL=1.
REQ-026 With tx_ready_i=0, tx_slots_p=2, issue three READER_STARTs -> the third asserts io_decode_error_o and READER_READY reads 0.
REQ-027 With READER_EV_ENABLE=1, tx_done_i in the same cycle as a write of 0x1 to 0x8030 -> pending stays 1 and irq_o=1 on the next cycle.
REQ-028 Read of 0x0804 with eth_mtu_p=2048 -> buf_raddr_o=0x804, and read_data_o equals buf_rdata_i on the next cycle; write to 0x0010 -> io_decode_error_o=1.
